// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared encodings for the hazard/forwarding unit and MDU scoreboard.
// Rev    : 1.0
// ============================================================================
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam int REG_ZERO = 0;

  typedef enum logic [0:0] {
    SB_RUN  = 1'b0,
    SB_WAIT = 1'b1
  } sb_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_forward_unit_if.sv
`default_nettype none
// ============================================================================
// Module : hazard_forward_unit_if
// Brief  : Pipeline-side bundle of the hazard/forwarding unit; the pipeline is
//          the master, the hazard unit the slave.
// Rev    : 1.0
// ============================================================================
interface hazard_forward_unit_if #(
  parameter int RAW     = 5,
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC*RAW-1:0] id_src_addr;
  logic [NUM_SRC-1:0]     id_src_used;
  logic                   id_is_mdu;
  logic [NUM_SRC*RAW-1:0] ex_src_addr;
  logic [RAW-1:0]         ex_dest_addr;
  logic                   ex_reg_write;
  logic                   ex_mem_read;
  logic [RAW-1:0]         mem_dest_addr;
  logic                   mem_reg_write;
  logic [RAW-1:0]         wb_dest_addr;
  logic                   wb_reg_write;
  logic                   mdu_start;
  logic [RAW-1:0]         mdu_dest_addr;
  logic [NUM_SRC*2-1:0]   fwd_sel;
  logic                   pc_write_en;
  logic                   ifid_write_en;
  logic                   idex_flush;
  logic                   mdu_busy;
  logic                   mdu_done;
  logic                   protocol_err;

  modport master (
    output id_src_addr, id_src_used, id_is_mdu, ex_src_addr, ex_dest_addr,
           ex_reg_write, ex_mem_read, mem_dest_addr, mem_reg_write,
           wb_dest_addr, wb_reg_write, mdu_start, mdu_dest_addr,
    input  fwd_sel, pc_write_en, ifid_write_en, idex_flush, mdu_busy,
           mdu_done, protocol_err
  );

  modport slave (
    input  id_src_addr, id_src_used, id_is_mdu, ex_src_addr, ex_dest_addr,
           ex_reg_write, ex_mem_read, mem_dest_addr, mem_reg_write,
           wb_dest_addr, wb_reg_write, mdu_start, mdu_dest_addr,
    output fwd_sel, pc_write_en, ifid_write_en, idex_flush, mdu_busy,
           mdu_done, protocol_err
  );
endinterface
`default_nettype wire

// File: rtl/mdu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : mdu_scoreboard
// Brief  : Tracks the single in-flight multi-cycle MDU op: countdown, latched
//          destination, busy/done and a sticky double-issue error flag.
// Rev    : 1.0
// ============================================================================
module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int RAW         = 5,
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mdu_start,
  input  logic [RAW-1:0] mdu_dest_addr,
  output logic           mdu_busy,
  output logic           mdu_done,
  output logic           protocol_err,
  output logic [RAW-1:0] busy_dest
);

  sb_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RAW-1:0] dest_q, dest_d;
  logic           perr_q, perr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    perr_d  = perr_q;
    case (state_q)
      SB_RUN: begin
        if (mdu_start) begin
          state_d = SB_WAIT;
          cnt_d   = CNT_W'(MDU_LATENCY);
          dest_d  = mdu_dest_addr;
        end
      end
      SB_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = SB_RUN;
        end
        // A second issue is dropped, not queued; only the error flag records it.
        if (mdu_start) begin
          perr_d = 1'b1;
        end
      end
      default: state_d = SB_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SB_RUN;
      cnt_q   <= '0;
      dest_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      perr_q  <= perr_d;
    end
  end

  assign mdu_busy     = (state_q == SB_WAIT) & ~rst;
  assign mdu_done     = mdu_busy & (cnt_q == CNT_W'(1));
  assign protocol_err = perr_q;
  assign busy_dest    = dest_q;

endmodule
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module : hazard_forward_unit
// Brief  : EX bypass select, ID load-use stall and MDU scoreboard stall.
//          Define HAZARD_PERF_CNT_EN to add stall_cycles/fwd_events counters.
// Rev    : 1.0
// ============================================================================
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int RAW         = 5,
  parameter int NUM_SRC     = 2,
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 3
) (
  input  logic                clk,
  input  logic                rst,
  hazard_forward_unit_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         fwd_events
`endif
);

  logic           sb_busy;
  logic           sb_done;
  logic           sb_perr;
  logic [RAW-1:0] sb_dest;

  mdu_scoreboard #(
    .RAW         (RAW),
    .MDU_LATENCY (MDU_LATENCY),
    .CNT_W       (CNT_W)
  ) u_mdu_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .mdu_start     (bus.mdu_start),
    .mdu_dest_addr (bus.mdu_dest_addr),
    .mdu_busy      (sb_busy),
    .mdu_done      (sb_done),
    .protocol_err  (sb_perr),
    .busy_dest     (sb_dest)
  );

  logic [NUM_SRC*2-1:0] w_fwd_sel;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
    logic [RAW-1:0] w_src;
    logic [1:0]     w_sel;

    assign w_src = bus.ex_src_addr[gi*RAW +: RAW];

    always_comb begin
      w_sel = FWD_RF;
      if (w_src != RAW'(REG_ZERO)) begin
        if (bus.mem_reg_write && (bus.mem_dest_addr == w_src)) begin
          w_sel = FWD_MEM;
        end else if (bus.wb_reg_write && (bus.wb_dest_addr == w_src)) begin
          w_sel = FWD_WB;
        end
      end
    end

    assign w_fwd_sel[gi*2 +: 2] = w_sel;
  end

  logic           w_load_use;
  logic           w_mdu_data;
  logic           w_mdu_struct;
  logic           w_stall;
  logic [RAW-1:0] w_id_src;

  // A zero source never hazards, which also masks a zero EX/MDU destination.
  always_comb begin
    w_load_use = 1'b0;
    w_mdu_data = 1'b0;
    w_id_src   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_id_src = bus.id_src_addr[i*RAW +: RAW];
      if (bus.id_src_used[i] && (w_id_src != RAW'(REG_ZERO))) begin
        if (bus.ex_mem_read && bus.ex_reg_write && (w_id_src == bus.ex_dest_addr)) begin
          w_load_use = 1'b1;
        end
        if ((sb_busy && (w_id_src == sb_dest)) ||
            (bus.mdu_start && (w_id_src == bus.mdu_dest_addr))) begin
          w_mdu_data = 1'b1;
        end
      end
    end
  end

  assign w_mdu_struct = bus.id_is_mdu & (sb_busy | bus.mdu_start);
  assign w_stall      = ~rst & (w_load_use | w_mdu_data | w_mdu_struct);

  assign bus.fwd_sel       = rst ? '0 : w_fwd_sel;
  assign bus.pc_write_en   = ~w_stall;
  assign bus.ifid_write_en = ~w_stall;
  assign bus.idex_flush    = w_stall;
  assign bus.mdu_busy      = sb_busy;
  assign bus.mdu_done      = sb_done;
  assign bus.protocol_err  = sb_perr;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] fwd_events_q, fwd_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    fwd_events_d   = fwd_events_q;
    if (w_stall && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (!rst && (|w_fwd_sel) && !(&fwd_events_q)) begin
      fwd_events_d = fwd_events_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fwd_events_q   <= fwd_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_events   = fwd_events_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_forward_unit
// Brief  : Directed scenarios plus random traffic against a cycle-indexed
//          reference model of forwarding, stalls and the MDU scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_hazard_forward_unit;
  localparam int RAW = 5, NUM_SRC = 2, L = 4, CNT_W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.RAW(RAW), .NUM_SRC(NUM_SRC)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, fwd_events;
`endif

  hazard_forward_unit #(
    .RAW(RAW), .NUM_SRC(NUM_SRC), .MDU_LATENCY(L), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .fwd_events   (fwd_events)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: the MDU is busy in cycles issue_cyc+1 .. issue_cyc+L.
  int             cyc       = 0;
  int             issue_cyc = -1000;
  logic [RAW-1:0] m_dst     = '0;
  bit             m_perr    = 0;
  int             m_stall_cnt = 0;
  int             m_fwd_cnt   = 0;
  bit             last_stall, last_fwd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit in_wait(input int c);
    return (issue_cyc >= 0) && (c > issue_cyc) && (c <= issue_cyc + L);
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [RAW-1:0] src);
    if (src == 0) return 2'd0;
    if (bus.mem_reg_write && bus.mem_dest_addr == src) return 2'd1;
    if (bus.wb_reg_write && bus.wb_dest_addr == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic clear_inputs();
    rst = 1'b0;
    bus.id_src_addr = '0; bus.id_src_used = '0; bus.id_is_mdu = 1'b0;
    bus.ex_src_addr = '0; bus.ex_dest_addr = '0; bus.ex_reg_write = 1'b0;
    bus.ex_mem_read = 1'b0; bus.mem_dest_addr = '0; bus.mem_reg_write = 1'b0;
    bus.wb_dest_addr = '0; bus.wb_reg_write = 1'b0;
    bus.mdu_start = 1'b0; bus.mdu_dest_addr = '0;
  endtask

  task automatic eval(input string tag);
    logic [2*NUM_SRC-1:0] e_fwd;
    logic [RAW-1:0]       s;
    bit lu, dh, sh, busy, done, st;
    #2;
    busy  = !rst && in_wait(cyc);
    done  = busy && (cyc == issue_cyc + L);
    e_fwd = '0;
    lu = 0; dh = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = bus.id_src_addr[i*RAW +: RAW];
      if (!rst) e_fwd[2*i +: 2] = ref_fwd(bus.ex_src_addr[i*RAW +: RAW]);
      if (bus.id_src_used[i] && s != 0) begin
        if (bus.ex_mem_read && bus.ex_reg_write && s == bus.ex_dest_addr) lu = 1;
        if ((busy && s == m_dst) || (bus.mdu_start && s == bus.mdu_dest_addr)) dh = 1;
      end
    end
    sh = bus.id_is_mdu && (busy || bus.mdu_start);
    st = !rst && (lu || dh || sh);
    last_stall = st;
    last_fwd   = (e_fwd != 0);
    check({tag, "/fwd_sel"},  32'(bus.fwd_sel), 32'(e_fwd));
    check({tag, "/pc_we"},    32'(bus.pc_write_en), 32'(!st));
    check({tag, "/ifid_we"},  32'(bus.ifid_write_en), 32'(!st));
    check({tag, "/flush"},    32'(bus.idex_flush), 32'(st));
    check({tag, "/busy"},     32'(bus.mdu_busy), 32'(busy));
    check({tag, "/done"},     32'(bus.mdu_done), 32'(done));
    check({tag, "/perr"},     32'(bus.protocol_err), 32'(m_perr));
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "/stall_cnt"}, stall_cycles, 32'(m_stall_cnt));
    check({tag, "/fwd_cnt"},   fwd_events, 32'(m_fwd_cnt));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      issue_cyc = -1000; m_dst = '0; m_perr = 0;
      m_stall_cnt = 0; m_fwd_cnt = 0;
    end else begin
      if (bus.mdu_start) begin
        if (in_wait(cyc)) m_perr = 1;
        else begin
          issue_cyc = cyc;
          m_dst     = bus.mdu_dest_addr;
        end
      end
      if (last_stall) m_stall_cnt++;
      if (last_fwd)   m_fwd_cnt++;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      clear_inputs();
      rst = 1'b1;
      bus.ex_src_addr = 10'h3FF; bus.mem_reg_write = 1'b1; bus.mem_dest_addr = 5'h1F;
      eval("reset");
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    do_reset(2);
    eval("post_reset");
    check("rst_perr", 32'(bus.protocol_err), 32'd0);
    tick();

    // Forwarding: MEM wins over WB, register 0 never forwards.
    bus.ex_src_addr = {5'd4, 5'd3};
    bus.mem_reg_write = 1'b1; bus.mem_dest_addr = 5'd3;
    bus.wb_reg_write  = 1'b1; bus.wb_dest_addr  = 5'd4;
    eval("fwd_a");
    check("fwd_a_const", 32'(bus.fwd_sel), 32'h9);
    tick();
    bus.wb_dest_addr = 5'd3;
    eval("fwd_b");
    check("fwd_b_const", 32'(bus.fwd_sel), 32'h1);
    tick();
    bus.ex_src_addr = '0; bus.mem_dest_addr = '0; bus.wb_dest_addr = '0;
    eval("fwd_zero");
    check("fwd_zero_const", 32'(bus.fwd_sel), 32'h0);
    tick();
`ifdef HAZARD_PERF_CNT_EN
    check("perf_fwd2", fwd_events, 32'd2);
`endif
    clear_inputs();

    // Load-use: one stall, then EX holds the bubble.
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dest_addr = 5'd7;
    bus.id_src_addr = {5'd2, 5'd7}; bus.id_src_used = 2'b01;
    eval("lu_stall");
    check("lu_pc", 32'(bus.pc_write_en), 32'd0);
    check("lu_flush", 32'(bus.idex_flush), 32'd1);
    tick();
    bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_dest_addr = '0;
    eval("lu_release");
    check("lu_rel_pc", 32'(bus.pc_write_en), 32'd1);
    tick();
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dest_addr = 5'd7;
    bus.id_src_used = 2'b00;
    eval("lu_unused");
    check("lu_unused_flush", 32'(bus.idex_flush), 32'd0);
    tick();
    clear_inputs();

    // MDU data dependence on r9.
    bus.id_src_addr = {5'd0, 5'd9}; bus.id_src_used = 2'b01;
    for (int k = 0; k <= 6; k++) begin
      bus.mdu_start = (k == 0); bus.mdu_dest_addr = 5'd9;
      eval("mdu_dep");
      check("mdu_dep_busy", 32'(bus.mdu_busy), 32'(k >= 1 && k <= 4));
      check("mdu_dep_done", 32'(bus.mdu_done), 32'(k == 4));
      check("mdu_dep_stall", 32'(bus.idex_flush), 32'(k <= 4));
      tick();
    end
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall6", stall_cycles, 32'd6);
`endif
    clear_inputs();

    // Structural conflict plus an illegal second issue.
    bus.id_is_mdu = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      bus.mdu_start = (k == 0 || k == 2);
      bus.mdu_dest_addr = (k == 0) ? 5'd12 : 5'd13;
      eval("mdu_struct");
      check("mdu_st_stall", 32'(bus.idex_flush), 32'(k <= 4));
      check("mdu_st_done", 32'(bus.mdu_done), 32'(k == 4));
      check("mdu_st_perr", 32'(bus.protocol_err), 32'(k >= 3));
      tick();
    end
    do_reset(1);

    // Reset in the middle of an MDU op.
    bus.id_src_addr = {5'd0, 5'd9}; bus.id_src_used = 2'b01;
    for (int k = 0; k <= 3; k++) begin
      rst = (k == 2);
      bus.mdu_start = (k == 0); bus.mdu_dest_addr = 5'd9;
      eval("mdu_rst");
      if (k >= 2) begin
        check("mdu_rst_busy", 32'(bus.mdu_busy), 32'd0);
        check("mdu_rst_done", 32'(bus.mdu_done), 32'd0);
        check("mdu_rst_stall", 32'(bus.idex_flush), 32'd0);
      end
      tick();
    end
    clear_inputs();

    // Random traffic over a small register range to force collisions.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NUM_SRC; i++) begin
        bus.id_src_addr[i*RAW +: RAW] = 5'($urandom_range(0, 7));
        bus.ex_src_addr[i*RAW +: RAW] = 5'($urandom_range(0, 7));
      end
      bus.id_src_used   = 2'($urandom);
      bus.id_is_mdu     = ($urandom_range(0, 3) == 0);
      bus.ex_dest_addr  = 5'($urandom_range(0, 7));
      bus.ex_reg_write  = 1'($urandom);
      bus.ex_mem_read   = 1'($urandom);
      bus.mem_dest_addr = 5'($urandom_range(0, 7));
      bus.mem_reg_write = 1'($urandom);
      bus.wb_dest_addr  = 5'($urandom_range(0, 7));
      bus.wb_reg_write  = 1'($urandom);
      bus.mdu_start     = ($urandom_range(0, 7) == 0);
      bus.mdu_dest_addr = 5'($urandom_range(0, 7));
      eval("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the MIPS32 pipeline forwarding logic.
- Combines three functions:
  - Per-operand EX-stage bypass selection from MEM and WB, for any number of source operands.
  - Load-use stall detection in ID.
  - A sequential scoreboard for the multi-cycle multiply/divide unit (MDU) that stalls dependent or structurally conflicting instructions.
- Sits beside the ID/EX pipeline registers and drives the EX operand muxes, PC/IF-ID write enables and the ID/EX bubble.

Parameters:
- RAW, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- MDU_LATENCY, 4, MDU busy cycles after issue (>=1).
- CNT_W, 3, MDU countdown width (>= clog2(MDU_LATENCY+1)).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_src_addr  in  NUM_SRC*RAW  ID-stage source addresses, operand i at [i*RAW +: RAW]
- id_src_used  in  NUM_SRC  operand i actually read by the ID instruction
- id_is_mdu  in  1  ID instruction is an MDU op
- ex_src_addr  in  NUM_SRC*RAW  EX-stage source addresses
- ex_dest_addr  in  RAW  EX destination
- ex_reg_write  in  1  EX writes a register
- ex_mem_read  in  1  EX instruction is a load
- mem_dest_addr  in  RAW  MEM destination
- mem_reg_write  in  1  MEM writes a register
- wb_dest_addr  in  RAW  WB destination
- wb_reg_write  in  1  WB writes a register
- mdu_start  in  1  MDU op issuing from EX this cycle
- mdu_dest_addr  in  RAW  MDU result destination
- fwd_sel  out  NUM_SRC*2  per EX operand: 0 regfile, 1 MEM, 2 WB
- pc_write_en  out  1  0 = hold PC
- ifid_write_en  out  1  0 = hold IF/ID
- idex_flush  out  1  1 = insert bubble into ID/EX
- mdu_busy  out  1  scoreboard in WAIT
- mdu_done  out  1  one-cycle pulse in last busy cycle
- protocol_err  out  1  sticky: mdu_start seen while busy

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=RUN, counter=0, latched dest=0, protocol_err=0.
  - While rst=1: fwd_sel=0, pc_write_en=1, ifid_write_en=1, idex_flush=0, mdu_busy=0, mdu_done=0.
- Register 0 never matches: no forwarding and no hazard for address 0.
- Forwarding (combinational, zero latency), per operand i:
  - 1 if mem_reg_write and mem_dest==ex_src[i]
  - else 2 if wb_reg_write and wb_dest==ex_src[i]
  - else 0
  - MEM beats WB when both match.
- Load-use hazard (combinational):
  - Condition: ex_mem_read & ex_reg_write & ex_dest!=0 & some i with id_src_used[i] & id_src[i]==ex_dest.
  - Exactly one stall cycle results, because the bubble clears EX.
- Scoreboard FSM, states RUN and WAIT:
  - RUN, mdu_start=1: load counter=MDU_LATENCY, latch mdu_dest_addr, go to WAIT.
  - WAIT: decrement the counter every cycle. mdu_done=1 when counter==1; next state is RUN.
  - mdu_busy=1 exactly MDU_LATENCY cycles, T+1..T+MDU_LATENCY, for issue at cycle T.
  - mdu_start in WAIT: ignored (no reload) and protocol_err set until rst.
  - Reset mid-operation: immediate RUN, scoreboard cleared, no mdu_done.
- MDU hazard:
  - Data: (state==WAIT & used source == latched dest) or (mdu_start & used source == mdu_dest_addr).
  - Structural: id_is_mdu & (state==WAIT | mdu_start).
- Stall output: stall = load-use | MDU hazard. When stall=1: pc_write_en=0, ifid_write_en=0, idex_flush=1. Otherwise 1/1/0.
- Simultaneous load-use and MDU hazard: a single stall, with the same outputs.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and fwd_events[31:0].
  - stall_cycles increments each stall cycle.
  - fwd_events increments each cycle any fwd_sel!=0.
  - Both saturate at all-ones; rst clears them.
- Undefined: neither port nor counter exists.

Decomposition:
- Package hazard_pkg:
  - fwd_sel encodings FWD_RF=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2.
  - Scoreboard state enum SB_RUN/SB_WAIT.
  - REG_ZERO constant.
- Sub-module mdu_scoreboard:
  - Holds the FSM, counter, latched dest, mdu_busy/mdu_done and protocol_err.
  - Outputs busy and dest to the top-level for comparison.

Test Plan:
- ex_src={3,4}; mem_dest=3 wr=1; wb_dest=3,4 wr=1 -> fwd_sel={1,2}. Repeat with ex_src=0 and matching dest 0 -> fwd_sel=0.
- ex_mem_read=1, ex_dest=7; id_src={7,x}, used=01 -> one cycle of pc_write_en=0, ifid_write_en=0, idex_flush=1. Same with used=00 -> no stall.
- mdu_start at T, dest=9, MDU_LATENCY=4 -> mdu_busy T+1..T+4, mdu_done only at T+4. ID reading r9 stalls T..T+4 and releases at T+5.
- Busy MDU, id_is_mdu=1 with no data dependence -> stall until RUN. Extra mdu_start while busy -> protocol_err=1, and done timing unchanged.
- rst at T+2 of an MDU op -> T+3: mdu_busy=0, no mdu_done, no stall on r9.
- With HAZARD_PERF_CNT_EN: the load-use scenario plus the 5-cycle MDU stall -> stall_cycles=6. Forwarding scenario, 2 cycles -> fwd_events=2.
